not16_bist: RTL and testbench

NOT16_BIST -- requirements
Module: not16_bist

---
 rtl/not16_bist_pkg.sv | 16 +
 rtl/not16_bist_thermo_step.sv | 11 +
 rtl/not_16.sv | 11 +
 rtl/not16_bist.sv | 125 ++++++++++++
 tb/tb_not16_bist.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/not16_bist_pkg.sv
// Shared definitions for the 16-bit inverter built-in self test.
package not16_bist_pkg;

    localparam int unsigned WIDTH       = 16;
    localparam int unsigned NUM_VECTORS = 17;
    localparam logic [4:0]  NO_FAIL_IDX = 5'd31;
    localparam logic [4:0]  LAST_IDX    = 5'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCheck,
        StDone
    } state_e;

endpackage

// File: rtl/not16_bist_thermo_step.sv
// Thermometer-code step: shifts in one more set bit from the LSB.
module thermo_step_16
    import not16_bist_pkg::*;
(
    input  logic [WIDTH-1:0] in_vec,
    output logic [WIDTH-1:0] out_vec
);

    assign out_vec = {in_vec[WIDTH-2:0], 1'b1};

endmodule

// File: rtl/not_16.sv
// Existing 16-bit inverter gate, reused as the golden reference.
module not_16
    import not16_bist_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    assign y = ~a;

endmodule

// File: rtl/not16_bist.sv
// BIST controller: walks 17 thermometer vectors through an external 16-bit
// inverter and records the mismatch count plus the first failing vector.
module not16_bist
    import not16_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] dut_in,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [4:0]       fail_count,
    output logic [4:0]       first_fail_idx,
    output logic [WIDTH-1:0] first_fail_data
);

    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES);

    state_e           state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] dut_in_d;
    logic             done_d;
    logic [4:0]       fail_count_d, first_fail_idx_d;
    logic [WIDTH-1:0] first_fail_data_d;

    logic [WIDTH-1:0] next_vec;
    logic [WIDTH-1:0] golden;
    logic             mismatch;

    thermo_step_16 u_step (
        .in_vec  (dut_in),
        .out_vec (next_vec)
    );

    not_16 u_ref (
        .a (dut_in),
        .y (golden)
    );

    assign mismatch = (dut_out != golden);

    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        cnt_d             = cnt_q;
        dut_in_d          = dut_in;
        done_d            = done;
        fail_count_d      = fail_count;
        first_fail_idx_d  = first_fail_idx;
        first_fail_data_d = first_fail_data;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    dut_in_d          = '0;
                    idx_d             = 5'd0;
                    cnt_d             = SettleLoad;
                    fail_count_d      = 5'd0;
                    first_fail_idx_d  = NO_FAIL_IDX;
                    first_fail_data_d = '0;
                    done_d            = 1'b0;
                    state_d           = StSettle;
                end
            end
            StSettle: begin
                // The loading edge counts as the first settle cycle.
                if (cnt_q <= 4'd1) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    fail_count_d = fail_count + 5'd1;
                    if (fail_count == 5'd0) begin
                        first_fail_idx_d  = idx_q;
                        first_fail_data_d = dut_out;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    idx_d    = idx_q + 5'd1;
                    dut_in_d = next_vec;
                    cnt_d    = SettleLoad;
                    state_d  = StSettle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            idx_q           <= 5'd0;
            cnt_q           <= 4'd0;
            dut_in          <= '0;
            done            <= 1'b0;
            fail_count      <= 5'd0;
            first_fail_idx  <= NO_FAIL_IDX;
            first_fail_data <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            cnt_q           <= cnt_d;
            dut_in          <= dut_in_d;
            done            <= done_d;
            fail_count      <= fail_count_d;
            first_fail_idx  <= first_fail_idx_d;
            first_fail_data <= first_fail_data_d;
        end
    end

    assign busy = (state_q == StSettle) || (state_q == StCheck);
    assign pass = done && (fail_count == 5'd0);

endmodule

// File: tb/tb_not16_bist.sv
// Scoreboard bench for not16_bist: directed runs against good and faulty inverters.
module tb_not16_bist;

    typedef struct {
        logic [4:0]  fc;
        logic [4:0]  ffi;
        logic [15:0] ffd;
        logic        pass;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start3 = 1'b0;
    int          mode = 0;

    logic [15:0] din, dout, ffd;
    logic        busy, done, pass;
    logic [4:0]  fc, ffi;

    logic [15:0] din3, dout3, ffd3;
    logic        busy3, done3, pass3;
    logic [4:0]  fc3, ffi3;

    exp_t q[$];
    exp_t q3[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // Inverter under test: 0 good, 1 bit 5 stuck at 1, 2 output tied low.
    always_comb begin
        dout = ~din;
        if (mode == 1) dout = ~din | 16'h0020;
        else if (mode == 2) dout = 16'h0000;
    end
    assign dout3 = ~din3;

    not16_bist dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .dut_in          (din),
        .dut_out         (dout),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .fail_count      (fc),
        .first_fail_idx  (ffi),
        .first_fail_data (ffd)
    );

    not16_bist #(.SETTLE_CYCLES(3)) dut3 (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start3),
        .dut_in          (din3),
        .dut_out         (dout3),
        .busy            (busy3),
        .done            (done3),
        .pass            (pass3),
        .fail_count      (fc3),
        .first_fail_idx  (ffi3),
        .first_fail_data (ffd3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event did not occur within its bound", name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dut_in"}, 32'(din), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_pass"}, 32'(pass), 32'h0);
        check({tag, "_fail_count"}, 32'(fc), 32'h0);
        check({tag, "_first_fail_idx"}, 32'(ffi), 32'd31);
        check({tag, "_first_fail_data"}, 32'(ffd), 32'h0);
    endtask

    task automatic pulse(input bit which3);
        @(posedge clk);
        #2;
        if (which3) start3 = 1'b1; else start = 1'b1;
        @(posedge clk);
        #2;
        start  = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_done(input bit which3, input string name);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((which3 ? done3 : done) == 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail_now(name);
    endtask

    // Monitor for the default instance: vector sequence, hold time, run results.
    initial begin : mon
        int          lat = 0;
        int          hold = 0;
        logic        done_p = 0, busy_p = 0;
        logic [15:0] prev = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lat = 0; hold = 0; done_p = 0; busy_p = 0; prev = din;
            end else begin
                if (busy) lat++;
                if (busy && !busy_p) begin
                    check("first_vector", 32'(din), 32'h0);
                    hold = 1;
                end else if (busy && din != prev) begin
                    check("next_vector", 32'(din), 32'({prev[14:0], 1'b1}));
                    check("hold_cycles", 32'(hold), 32'd2);
                    hold = 1;
                end else if (busy) begin
                    hold++;
                end
                if (done && !done_p) begin
                    if (q.size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        e = q.pop_front();
                        check("fail_count", 32'(fc), 32'(e.fc));
                        check("first_fail_idx", 32'(ffi), 32'(e.ffi));
                        check("first_fail_data", 32'(ffd), 32'(e.ffd));
                        check("pass", 32'(pass), 32'(e.pass));
                        check("busy_cycles", 32'(lat), 32'(e.lat));
                        check("dut_in_final", 32'(din), 32'hFFFF);
                    end
                    lat = 0;
                end
                done_p = done; busy_p = busy; prev = din;
            end
        end
    end

    // Monitor for the SETTLE_CYCLES=3 instance.
    initial begin : mon3
        int          lat = 0;
        int          hold = 0;
        logic        done_p = 0, busy_p = 0;
        logic [15:0] prev = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lat = 0; hold = 0; done_p = 0; busy_p = 0; prev = din3;
            end else begin
                if (busy3) lat++;
                if (busy3 && !busy_p) begin
                    hold = 1;
                end else if (busy3 && din3 != prev) begin
                    check("hold_cycles_s3", 32'(hold), 32'd4);
                    hold = 1;
                end else if (busy3) begin
                    hold++;
                end
                if (done3 && !done_p) begin
                    if (q3.size() == 0) begin
                        fail_now("unexpected_done_s3");
                    end else begin
                        e = q3.pop_front();
                        check("fail_count_s3", 32'(fc3), 32'(e.fc));
                        check("first_fail_idx_s3", 32'(ffi3), 32'(e.ffi));
                        check("pass_s3", 32'(pass3), 32'(e.pass));
                        check("busy_cycles_s3", 32'(lat), 32'(e.lat));
                    end
                    lat = 0;
                end
                done_p = done3; busy_p = busy3; prev = din3;
            end
        end
    end

    initial begin : stim
        bit seen;
        #23;
        check_reset_outputs("por");
        check("por_s3_busy", 32'(busy3), 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Good inverter.
        q.push_back('{fc: 5'd0, ffi: 5'd31, ffd: 16'h0000, pass: 1'b1, lat: 34});
        pulse(0);
        wait_done(0, "done_good");

        // Bit 5 stuck at 1: idx 6..16 fail, first at idx 6 reading FFE0.
        mode = 1;
        q.push_back('{fc: 5'd11, ffi: 5'd6, ffd: 16'hFFE0, pass: 1'b0, lat: 34});
        pulse(0);
        wait_done(0, "done_stuck5");

        // Output tied low: only idx 16 (expected 0000) matches.
        mode = 2;
        q.push_back('{fc: 5'd16, ffi: 5'd0, ffd: 16'h0000, pass: 1'b0, lat: 34});
        pulse(0);
        wait_done(0, "done_zero");

        // Restart from DONE clears results; starts during busy are ignored.
        mode = 0;
        q.push_back('{fc: 5'd0, ffi: 5'd31, ffd: 16'h0000, pass: 1'b1, lat: 34});
        pulse(0);
        check("restart_done", 32'(done), 32'h0);
        check("restart_fail_count", 32'(fc), 32'h0);
        check("restart_first_fail_idx", 32'(ffi), 32'd31);
        check("restart_busy", 32'(busy), 32'h1);
        for (int k = 0; k < 3; k++) begin
            repeat (4) @(posedge clk);
            pulse(0);
        end
        wait_done(0, "done_restart");

        // Longer settle time.
        q3.push_back('{fc: 5'd0, ffi: 5'd31, ffd: 16'h0000, pass: 1'b1, lat: 68});
        pulse(1);
        wait_done(1, "done_s3");

        // Reset at idx 8 discards the run.
        pulse(0);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (din == 16'h00FF) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail_now("reach_idx8");
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        q.push_back('{fc: 5'd0, ffi: 5'd31, ffd: 16'h0000, pass: 1'b1, lat: 34});
        pulse(0);
        wait_done(0, "done_after_reset");

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(q.size()), 32'd0);
        check("scoreboard_empty_s3", 32'(q3.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
